cmul_arbiter: RTL and testbench

CMUL_ARBITER -- requirements
Module: cmul_arbiter

---
 rtl/cmul_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_cmul_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmul_arbiter.sv
// cmul_arbiter
//   Shares one complex multiplier among NREQ requesters. A round-robin
//   arbiter picks one requester per cycle; its operands enter a two-stage
//   pipeline (S1: captured operands, S2: finished product) that stalls as a
//   whole when the result at the output is not taken.
//
// Ports
//   clk        single clock, all state updates on the rising edge
//   rst        synchronous, active-high reset
//   req_valid  per-requester: operand pair presented
//   req_ready  per-requester: operands accepted this cycle (one-hot or zero)
//   req_a_re, req_a_im, req_b_re, req_b_im
//              packed signed operands, requester i in bits [i*W +: W]
//   res_valid  result present
//   res_ready  consumer accepts the result
//   res_id     requester index of the result
//   res_re, res_im
//              exact signed product a*b, 2W+1 bits each
//   idle       nothing in flight in either pipeline stage
module cmul_arbiter #(
    parameter int W    = 16,
    parameter int NREQ = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*W-1:0]     req_a_re,
    input  logic [NREQ*W-1:0]     req_a_im,
    input  logic [NREQ*W-1:0]     req_b_re,
    input  logic [NREQ*W-1:0]     req_b_im,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [1:0]            res_id,
    output logic [2*W:0]          res_re,
    output logic [2*W:0]          res_im,
    output logic                  idle
);

    // Requester index width; NREQ is fixed at 4 in this revision, so a
    // 2-bit index wraps exactly modulo NREQ.
    localparam int IW = 2;
    // Intermediate width for the three-multiply form. The partial products
    // need 2W+1 bits; their sum/difference can transiently need one more
    // before the exact result (which always fits 2W+1) is taken.
    localparam int PW = 2 * W + 2;

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic                 s1_valid;
    logic [IW-1:0]        s1_id;
    logic signed [W-1:0]  s1_a_re;
    logic signed [W-1:0]  s1_a_im;
    logic signed [W-1:0]  s1_b_re;
    logic signed [W-1:0]  s1_b_im;

    logic                 s2_valid;
    logic [IW-1:0]        s2_id;
    logic [2*W:0]         s2_re;
    logic [2*W:0]         s2_im;

    logic [IW-1:0]        ptr;

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic advance;
    assign advance = !s2_valid || res_ready;

    // ------------------------------------------------------------------
    // Round-robin grant: first valid requester starting at ptr
    // ------------------------------------------------------------------
    logic          grant_found;
    logic [IW-1:0] grant_id;
    logic [IW-1:0] cand;

    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = ptr + IW'(k);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    // Ready is also held low during reset so no transfer is signalled on an
    // edge that is about to clear the pipeline.
    logic transfer;
    always_comb begin
        req_ready = '0;
        if (grant_found && advance && !rst) begin
            req_ready = NREQ'(1) << grant_id;
        end
    end
    assign transfer = |req_ready;

    // ------------------------------------------------------------------
    // Operand selection for the granted requester
    // ------------------------------------------------------------------
    logic [W-1:0] sel_a_re;
    logic [W-1:0] sel_a_im;
    logic [W-1:0] sel_b_re;
    logic [W-1:0] sel_b_im;

    always_comb begin
        sel_a_re = req_a_re[int'(grant_id) * W +: W];
        sel_a_im = req_a_im[int'(grant_id) * W +: W];
        sel_b_re = req_b_re[int'(grant_id) * W +: W];
        sel_b_im = req_b_im[int'(grant_id) * W +: W];
    end

    // ------------------------------------------------------------------
    // Three-multiply complex product on S1 contents
    //   k1 = b_re*(a_re+a_im), k2 = a_re*(b_im-b_re), k3 = a_im*(b_re+b_im)
    //   re = k1-k3, im = k1+k2
    // All operands are sign-extended before combining so nothing wraps.
    // ------------------------------------------------------------------
    logic signed [W:0]    sum_a;
    logic signed [W:0]    diff_b;
    logic signed [W:0]    sum_b;
    logic signed [PW-1:0] k1;
    logic signed [PW-1:0] k2;
    logic signed [PW-1:0] k3;
    logic [2*W:0]         prod_re;
    logic [2*W:0]         prod_im;

    always_comb begin
        sum_a   = (W+1)'(s1_a_re) + (W+1)'(s1_a_im);
        diff_b  = (W+1)'(s1_b_im) - (W+1)'(s1_b_re);
        sum_b   = (W+1)'(s1_b_re) + (W+1)'(s1_b_im);
        k1      = PW'(s1_b_re) * PW'(sum_a);
        k2      = PW'(s1_a_re) * PW'(diff_b);
        k3      = PW'(s1_a_im) * PW'(sum_b);
        prod_re = (2*W+1)'(k1 - k3);
        prod_im = (2*W+1)'(k1 + k2);
    end

    // ------------------------------------------------------------------
    // Pipeline registers and arbitration pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_id    <= '0;
            s1_a_re  <= '0;
            s1_a_im  <= '0;
            s1_b_re  <= '0;
            s1_b_im  <= '0;
            s2_valid <= 1'b0;
            s2_id    <= '0;
            s2_re    <= '0;
            s2_im    <= '0;
            ptr      <= '0;
        end else begin
            if (advance) begin
                s2_valid <= s1_valid;
                s2_id    <= s1_id;
                s2_re    <= prod_re;
                s2_im    <= prod_im;
                s1_valid <= transfer;
                s1_id    <= grant_id;
                s1_a_re  <= sel_a_re;
                s1_a_im  <= sel_a_im;
                s1_b_re  <= sel_b_re;
                s1_b_im  <= sel_b_im;
            end
            if (transfer) begin
                ptr <= grant_id + IW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign res_valid = s2_valid;
    assign res_id    = s2_id;
    assign res_re    = s2_re;
    assign res_im    = s2_im;
    assign idle      = !s1_valid && !s2_valid;

endmodule

// File: tb/tb_cmul_arbiter.sv
// tb_cmul_arbiter
//   Directed vectors with hand-computed results, plus a cycle-level
//   reference model that runs alongside the whole test (including a
//   random-traffic phase) and predicts grants, results and idle.
module tb_cmul_arbiter;

    localparam int W    = 16;
    localparam int NREQ = 4;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a_re;
    logic [NREQ*W-1:0] req_a_im;
    logic [NREQ*W-1:0] req_b_re;
    logic [NREQ*W-1:0] req_b_im;
    logic              res_valid;
    logic              res_ready;
    logic [1:0]        res_id;
    logic [2*W:0]      res_re;
    logic [2*W:0]      res_im;
    logic              idle;

    logic signed [W-1:0] a_re_v [NREQ];
    logic signed [W-1:0] a_im_v [NREQ];
    logic signed [W-1:0] b_re_v [NREQ];
    logic signed [W-1:0] b_im_v [NREQ];

    int n_checks;
    int n_fail;

    cmul_arbiter #(.W(W), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a_re  (req_a_re),
        .req_a_im  (req_a_im),
        .req_b_re  (req_b_re),
        .req_b_im  (req_b_im),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_re    (res_re),
        .res_im    (res_im),
        .idle      (idle)
    );

    always_comb begin
        req_a_re = '0;
        req_a_im = '0;
        req_b_re = '0;
        req_b_im = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a_re[i*W +: W] = a_re_v[i];
            req_a_im[i*W +: W] = a_im_v[i];
            req_b_re[i*W +: W] = b_re_v[i];
            req_b_im[i*W +: W] = b_im_v[i];
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input longint observed, input longint expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int ar, input int ai, input int br, input int bi);
        a_re_v[i] = W'(ar);
        a_im_v[i] = W'(ai);
        b_re_v[i] = W'(br);
        b_im_v[i] = W'(bi);
    endtask

    // Simple operand pattern: a_i = (i+1, 0), b_i = (1, 0) -> re = i+1, im = 0
    task automatic pattern_ops();
        for (int i = 0; i < NREQ; i++) set_op(i, i + 1, 0, 1, 0);
    endtask

    function automatic longint sx(input logic [2*W:0] v);
        return longint'($signed(v));
    endfunction

    // ------------------------------------------------------------------
    // Reference model, evaluated mid-cycle on the falling edge
    // ------------------------------------------------------------------
    bit        armed;
    bit        m_s1v, m_s2v;
    int        m_ptr;
    int        m_s1_id, m_s2_id;
    longint    m_s1_re, m_s1_im, m_s2_re, m_s2_im;
    bit        m_adv, m_found;
    int        m_g, m_idx;
    logic [3:0] m_exp_ready;
    int        n_emitted;

    initial begin
        armed = 0;
        n_emitted = 0;
        forever begin
            @(negedge clk);
            m_adv   = !m_s2v || res_ready;
            m_found = 0;
            m_g     = 0;
            m_exp_ready = 4'b0000;
            if (armed && !rst && m_adv) begin
                for (int k = 0; k < NREQ; k++) begin
                    m_idx = (m_ptr + k) % NREQ;
                    if (!m_found && req_valid[m_idx]) begin
                        m_found = 1;
                        m_g     = m_idx;
                    end
                end
                if (m_found) m_exp_ready[m_g] = 1'b1;
            end
            if (armed) begin
                check("mon_req_ready", longint'(req_ready), longint'(m_exp_ready));
                check("mon_res_valid", longint'(res_valid), longint'(m_s2v));
                check("mon_idle", longint'(idle), longint'(!(m_s1v || m_s2v)));
                if (m_s2v) begin
                    check("mon_res_id", longint'(res_id), longint'(m_s2_id));
                    check("mon_res_re", sx(res_re), m_s2_re);
                    check("mon_res_im", sx(res_im), m_s2_im);
                    if (res_ready && !rst) n_emitted++;
                end
            end
            if (rst) begin
                armed = 1;
                m_s1v = 0;
                m_s2v = 0;
                m_ptr = 0;
                m_s1_id = 0;
                m_s2_id = 0;
            end else if (armed && m_adv) begin
                m_s2v   = m_s1v;
                m_s2_id = m_s1_id;
                m_s2_re = m_s1_re;
                m_s2_im = m_s1_im;
                m_s1v   = m_found;
                if (m_found) begin
                    m_s1_id = m_g;
                    m_s1_re = longint'(a_re_v[m_g]) * longint'(b_re_v[m_g])
                            - longint'(a_im_v[m_g]) * longint'(b_im_v[m_g]);
                    m_s1_im = longint'(a_re_v[m_g]) * longint'(b_im_v[m_g])
                            + longint'(a_im_v[m_g]) * longint'(b_re_v[m_g]);
                    m_ptr   = (m_g + 1) % NREQ;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed and random stimulus
    // ------------------------------------------------------------------
    logic [3:0] one;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        one       = 4'b0001;
        rst       = 1'b1;
        req_valid = 4'hF;
        res_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_op(i, 0, 0, 0, 0);

        // Reset state, with every requester asking
        tick();
        tick();
        check("rst_res_valid", longint'(res_valid), 0);
        check("rst_res_id", longint'(res_id), 0);
        check("rst_res_re", sx(res_re), 0);
        check("rst_res_im", sx(res_im), 0);
        check("rst_req_ready", longint'(req_ready), 0);
        check("rst_idle", longint'(idle), 1);

        // Single requester 2: (3+2j)*(2+3j) = 0 + 13j
        tick();
        rst       = 1'b0;
        req_valid = 4'b0100;
        set_op(2, 3, 2, 2, 3);
        #1;
        check("single_ready_t", longint'(req_ready), 4);
        tick();
        req_valid = 4'b0000;
        #1;
        check("single_valid_t1", longint'(res_valid), 0);
        tick();
        check("single_valid_t2", longint'(res_valid), 1);
        check("single_re", sx(res_re), 0);
        check("single_im", sx(res_im), 13);
        check("single_id", longint'(res_id), 2);

        // All four requesting for 8 cycles: grants and results 0,1,2,3,0,1,2,3
        tick();
        rst       = 1'b1;
        req_valid = 4'b0000;
        pattern_ops();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) tick();
            req_valid = (c < 8) ? 4'hF : 4'h0;
            #1;
            if (c < 8) check("rr_ready", longint'(req_ready), longint'(one << (c % 4)));
            if (c >= 2) begin
                check("rr_res_valid", longint'(res_valid), 1);
                check("rr_res_id", longint'(res_id), longint'((c - 2) % 4));
                check("rr_res_re", sx(res_re), longint'((c - 2) % 4 + 1));
            end
        end

        // Operand extremes (pointer is back at 0)
        tick();
        set_op(1, -32768, -32768, -32768, 32767);
        set_op(3, -32768, -32768, -32768, -32768);
        req_valid = 4'b1010;
        #1;
        check("ext_ready0", longint'(req_ready), 2);
        tick();
        req_valid = 4'b1000;
        #1;
        check("ext_ready1", longint'(req_ready), 8);
        tick();
        req_valid = 4'b0000;
        #1;
        check("ext1_id", longint'(res_id), 1);
        check("ext1_re", sx(res_re), 64'sd2147450880);
        check("ext1_im", sx(res_im), 64'sd32768);
        tick();
        check("ext2_id", longint'(res_id), 3);
        check("ext2_re", sx(res_re), 0);
        check("ext2_im", sx(res_im), 64'sd2147483648);

        // Output stall for 3 cycles with both stages full
        tick();
        pattern_ops();
        req_valid = 4'hF;
        res_ready = 1'b1;
        #1;
        check("stall_ready_c0", longint'(req_ready), 1);
        tick();
        check("stall_ready_c1", longint'(req_ready), 2);
        check("stall_valid_c1", longint'(res_valid), 0);
        for (int c = 2; c < 5; c++) begin
            tick();
            res_ready = 1'b0;
            #1;
            check("stall_ready_held", longint'(req_ready), 0);
            check("stall_valid_held", longint'(res_valid), 1);
            check("stall_id_held", longint'(res_id), 0);
            check("stall_re_held", sx(res_re), 1);
            check("stall_idle", longint'(idle), 0);
        end
        tick();
        res_ready = 1'b1;
        #1;
        check("stall_rel_ready", longint'(req_ready), 4);
        check("stall_rel_id0", longint'(res_id), 0);
        tick();
        check("stall_rel_ready2", longint'(req_ready), 8);
        check("stall_rel_id1", longint'(res_id), 1);
        check("stall_rel_re1", sx(res_re), 2);
        tick();
        req_valid = 4'b0000;
        #1;
        check("stall_rel_id2", longint'(res_id), 2);
        check("stall_rel_re2", sx(res_re), 3);
        tick();
        check("stall_rel_id3", longint'(res_id), 3);
        check("stall_rel_re3", sx(res_re), 4);
        tick();
        check("stall_drained", longint'(res_valid), 0);
        check("stall_idle_end", longint'(idle), 1);

        // Reset with two operations in flight (pointer at 0)
        tick();
        req_valid = 4'b0110;
        res_ready = 1'b0;
        #1;
        check("flush_ready_c0", longint'(req_ready), 2);
        tick();
        check("flush_ready_c1", longint'(req_ready), 4);
        tick();
        rst = 1'b1;
        #1;
        check("flush_ready_rst", longint'(req_ready), 0);
        check("flush_res_id_before", longint'(res_id), 1);
        tick();
        rst = 1'b0;
        #1;
        check("flush_idle", longint'(idle), 1);
        check("flush_res_valid", longint'(res_valid), 0);
        check("flush_regrant", longint'(req_ready), 2);
        tick();
        req_valid = 4'b0000;
        res_ready = 1'b1;
        #1;
        check("flush_valid_c4", longint'(res_valid), 0);
        tick();
        check("flush_valid_c5", longint'(res_valid), 1);
        check("flush_id_c5", longint'(res_id), 1);
        tick();
        check("flush_valid_c6", longint'(res_valid), 0);

        // Random traffic, checked by the reference model
        for (int c = 0; c < 400; c++) begin
            tick();
            req_valid = 4'($urandom_range(0, 15));
            res_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    set_op(i, -32768, ($urandom_range(0, 1) != 0) ? 32767 : -32768,
                           -32768, ($urandom_range(0, 1) != 0) ? 32767 : -32768);
                end else begin
                    a_re_v[i] = W'($urandom);
                    a_im_v[i] = W'($urandom);
                    b_re_v[i] = W'($urandom);
                    b_im_v[i] = W'($urandom);
                end
            end
        end
        tick();
        rst       = 1'b0;
        req_valid = 4'b0000;
        res_ready = 1'b1;
        repeat (3) tick();
        check("final_idle", longint'(idle), 1);
        check("results_emitted", longint'(n_emitted > 100), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
